// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with a latency down-counter and busy flag.
// Optional abort path enabled by defining MDU_FLUSH_EN; otherwise flush is ignored.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int DATA_W  = 32;
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] p_hi;
  logic [DATA_W-1:0] p_lo;
  logic              p_keep;
  logic              flush_act;

`ifdef MDU_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0 & flush;
`endif

  // Signed divide returning {remainder, quotient}; the one overflow case is pinned explicitly.
  function automatic logic [2*DATA_W-1:0] div_signed(input logic signed [DATA_W-1:0] n,
                                                      input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if (d == '0) begin
      q = '0;
      r = '0;
    end else if (n == {1'b1, {(DATA_W-1){1'b0}}} && d == -1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] div_unsigned(input logic [DATA_W-1:0] n,
                                                        input logic [DATA_W-1:0] d);
    if (d == '0) return '0;
    return {n % d, n / d};
  endfunction

  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [2*DATA_W-1:0]        quo_rem_s;
  logic [2*DATA_W-1:0]        quo_rem_u;
  logic [DATA_W-1:0]          res_hi;
  logic [DATA_W-1:0]          res_lo;
  logic [CNT_W-1:0]           res_cnt;
  logic                       res_keep;

  assign a_s       = $signed(rs_val);
  assign b_s       = $signed(rt_val);
  assign prod_s    = a_s * b_s;
  assign prod_u    = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};
  assign quo_rem_s = div_signed(a_s, b_s);
  assign quo_rem_u = div_unsigned(rs_val, rt_val);

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    res_cnt  = MULT_N;
    res_keep = 1'b0;
    case (mdop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        {res_hi, res_lo} = quo_rem_s;
        res_cnt  = DIV_N;
        res_keep = (rt_val == '0);
      end
      OP_DIVU: begin
        {res_hi, res_lo} = quo_rem_u;
        res_cnt  = DIV_N;
        res_keep = (rt_val == '0);
      end
      default: ;
    endcase
  end

  // Accept in IDLE, count down in BUSY, commit pending HI/LO on the last busy edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_keep <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == S_IDLE) begin
      if (start && !flush_act) begin
        case (mdop)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            p_hi   <= res_hi;
            p_lo   <= res_lo;
            p_keep <= res_keep;
            cnt    <= res_cnt;
            state  <= S_BUSY;
          end
          OP_MTHI: hi <= rs_val;
          OP_MTLO: lo <= rs_val;
          default: ;
        endcase
      end
    end else begin
      if (flush_act) begin
        state <= S_IDLE;
        cnt   <= '0;
        p_hi  <= '0;
        p_lo  <= '0;
      end else if (cnt == CNT_ONE) begin
        if (!p_keep) begin
          hi <= p_hi;
          lo <= p_lo;
        end
        cnt   <= '0;
        state <= S_IDLE;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed + randomized bench for mdu_sequencer; expected HI/LO come from 64-bit arithmetic.
// Flush expectations follow MDU_FLUSH_EN when it is defined for the build.
module tb_mdu_sequencer;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Architectural result of an op, from plain 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = exp_hi;
    nl = exp_lo;
    case (op)
      OP_MULT: begin
        p  = 64'(sa * sb);
        nh = p[63:32];
        nl = p[31:0];
      end
      OP_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        nh = p[63:32];
        nl = p[31:0];
      end
      OP_DIV: if (b != 0) begin
        q  = sa / sb;
        r  = sa % sb;
        nl = q[31:0];
        nh = r[31:0];
      end
      OP_DIVU: if (b != 0) begin
        nl = a / b;
        nh = a % b;
      end
      default: ;
    endcase
  endtask

  // Issue one mult/div; optionally flush in busy cycle flush_at and/or fire a stray start in ms_at.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int ms_at, input string tag);
    int          n;
    logic [31:0] nh, nl;
    bit          aborted;
    n = (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
    model(op, a, b, nh, nl);
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; mdop = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0; rs_val = $urandom; rt_val = $urandom;
    for (int i = 1; i <= n; i++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " hi hold"}, hi, exp_hi);
      if (i == flush_at) begin
        flush = 1'b1;
`ifdef MDU_FLUSH_EN
        aborted = 1'b1;
`endif
      end
      if (i == ms_at) begin
        start = 1'b1; mdop = OP_MULT; rs_val = $urandom; rt_val = $urandom;
      end
      @(negedge clk);
      flush = 1'b0; start = 1'b0; mdop = 4'd0;
      if (aborted) break;
    end
    check({tag, " busy done"}, 32'(busy), 32'd0);
    if (!aborted) begin
      exp_hi = nh;
      exp_lo = nl;
    end
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v, input bit with_flush,
                         input string tag);
    @(negedge clk);
    start = 1'b1; mdop = op; rs_val = v; flush = with_flush;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0; flush = 1'b0;
`ifdef MDU_FLUSH_EN
    if (!with_flush) begin
`else
    begin
`endif
      if (op == OP_MTHI) exp_hi = v;
      if (op == OP_MTLO) exp_lo = v;
    end
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    // Reset with a concurrent start: reset must win.
    start = 1'b1; mdop = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0; mdop = 4'd0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    check("reset no start", 32'(busy), 32'd0);

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         0, 0, "mult -2*3");
    check("mult -2*3 const hi", hi, 32'hFFFF_FFFF);
    check("mult -2*3 const lo", lo, 32'hFFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu max");
    check("multu const hi", hi, 32'hFFFF_FFFE);
    check("multu const lo", lo, 32'h0000_0001);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, "div -7/2");
    check("div const hi", hi, 32'hFFFF_FFFF);
    check("div const lo", lo, 32'hFFFF_FFFD);
    run_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2,         0, 0, "divu");
    check("divu const hi", hi, 32'd1);
    check("divu const lo", lo, 32'h7FFF_FFFC);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div overflow");
    check("div ovf const lo", lo, 32'h8000_0000);

    move_to(OP_MTHI, 32'h11, 1'b0, "mthi");
    move_to(OP_MTLO, 32'h22, 1'b0, "mtlo");
    run_op(OP_DIV, 32'd1234, 32'd0, 0, 4, "div by zero");
    check("dz const hi", hi, 32'h11);
    check("dz const lo", lo, 32'h22);
    run_op(OP_DIVU, 32'd77, 32'd0, 0, 0, "divu by zero");

    run_op(OP_MULT, 32'd6, 32'd7, 3, 0, "flush mid");
    run_op(OP_MULT, 32'd6, 32'd7, 5, 0, "flush commit");
    move_to(OP_MTHI, 32'h55, 1'b1, "mthi flushed");

    // Reset in busy cycle 4 of a divide.
    @(negedge clk);
    start = 1'b1; mdop = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; mdop = 4'd0;
    repeat (3) @(negedge clk);
    check("rst mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("rst mid busy clr", 32'(busy), 32'd0);
    check("rst mid hi", hi, 32'd0);
    check("rst mid lo", lo, 32'd0);
    run_op(OP_MULT, 32'd6, 32'd7, 0, 0, "mult after rst");
    check("mult after rst lo", lo, 32'd42);

    // Back-to-back randomized traffic, including unused opcodes.
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 5));
      if (op <= OP_DIVU) begin
        run_op(op, a, b, 0, 0, "rand md");
      end else if (op <= OP_MTLO) begin
        move_to(op, a, 1'b0, "rand mv");
      end else begin
        op = 4'($urandom_range(7, 15));
        move_to(op, a, 1'b0, "rand nop");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
